// File: rtl/syn_gpu_job_sched.sv
// Purpose: in-order 4-entry job queue feeding the euclid (draw) and picasso (fill) engines, with outstanding-job tracking.
// Latency: a job accepted in cycle N into an empty queue with idle engines raises its start pulse in cycle N+2.
// Backpressure: job_ready drops while 4 jobs are queued; the queue head waits for its engine and ordering hazards to clear.
module syn_gpu_job_sched #(
    parameter int DRAW_W       = 64,
    parameter int FILL_W       = 48,
    parameter int JOB_W        = 64,
    parameter int STRICT_ORDER = 1
) (
    input  logic              clk_ir,
    input  logic              rst_il,
    input  logic              job_valid,
    input  logic              job_type,
    input  logic [JOB_W-1:0]  job_data,
    output logic              job_ready,
    output logic              euclid_job_start,
    output logic [DRAW_W-1:0] euclid_job_data,
    input  logic              euclid_busy,
    input  logic              euclid_job_done,
    output logic              picasso_job_start,
    output logic [FILL_W-1:0] picasso_job_data,
    input  logic              picasso_busy,
    input  logic              picasso_job_done,
    output logic [2:0]        pending_cnt,
    output logic [7:0]        done_cnt,
    output logic              sched_idle,
    output logic              err_spurious_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [JOB_W-1:0] q_data [4];
    logic             q_type [4];
    logic [1:0]       wr_ptr, rd_ptr;
    logic [2:0]       cnt, cnt_nxt;
    logic             push, pop;
    logic             head_vld, head_type;
    logic [JOB_W-1:0] head_data;
    logic             eu_out, pi_out;
    logic             iss_type;
    logic             draw_ok, fill_ok, issue_ok, enter_issue;
    logic             eu_done_ok, pi_done_ok;

    // Ready comes only from the registered count, so a full queue never accepts a push.
    assign job_ready   = (cnt < 3'd4);
    assign push        = job_valid & job_ready;
    assign pop         = (state == ST_ISSUE);
    assign pending_cnt = cnt;
    assign head_vld    = (cnt != 3'd0);
    assign head_type   = q_type[rd_ptr];
    assign head_data   = q_data[rd_ptr];

    // A draw may overlap an outstanding fill only in relaxed mode. A fill never overlaps
    // an outstanding draw: the fill reads framebuffer contents the draw is still writing.
    assign draw_ok  = !eu_out && !euclid_busy && ((STRICT_ORDER == 0) || !pi_out);
    assign fill_ok  = !pi_out && !picasso_busy && !eu_out;
    assign issue_ok = head_vld && (head_type ? fill_ok : draw_ok);

    // Done pulses only count when the engine really has a job outstanding.
    assign eu_done_ok = euclid_job_done && eu_out;
    assign pi_done_ok = picasso_job_done && pi_out;

    assign sched_idle = (cnt == 3'd0) && !eu_out && !pi_out && (state == ST_IDLE);

    // Queue occupancy after this cycle's push and pop.
    always_comb begin
        cnt_nxt = cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + 3'd1;
            2'b01:   cnt_nxt = cnt - 3'd1;
            default: cnt_nxt = cnt;
        endcase
    end

    // Queue storage; contents need no reset because the count qualifies them.
    always_ff @(posedge clk_ir) begin
        if (push) begin
            q_data[wr_ptr] <= job_data;
            q_type[wr_ptr] <= job_type;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            cnt    <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            cnt <= cnt_nxt;
        end
    end

    // Next-state and start pulses: ISSUE always lasts exactly one cycle.
    always_comb begin
        state_nxt         = state;
        enter_issue       = 1'b0;
        euclid_job_start  = 1'b0;
        picasso_job_start = 1'b0;
        case (state)
            ST_IDLE, ST_WAIT: begin
                if (!head_vld) begin
                    state_nxt = ST_IDLE;
                end else if (issue_ok) begin
                    state_nxt   = ST_ISSUE;
                    enter_issue = 1'b1;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_ISSUE: begin
                euclid_job_start  = !iss_type;
                picasso_job_start = iss_type;
                state_nxt         = (cnt_nxt != 3'd0) ? ST_WAIT : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register plus engine descriptors, which are reloaded only when a job is issued.
    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            state            <= ST_IDLE;
            iss_type         <= 1'b0;
            euclid_job_data  <= '0;
            picasso_job_data <= '0;
        end else begin
            state <= state_nxt;
            if (enter_issue) begin
                iss_type <= head_type;
                if (!head_type) euclid_job_data  <= head_data[DRAW_W-1:0];
                else            picasso_job_data <= head_data[FILL_W-1:0];
            end
        end
    end

    // Outstanding flags: a start wins over a done arriving in the same cycle.
    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            eu_out <= 1'b0;
            pi_out <= 1'b0;
        end else begin
            if (euclid_job_start)     eu_out <= 1'b1;
            else if (euclid_job_done) eu_out <= 1'b0;
            if (picasso_job_start)     pi_out <= 1'b1;
            else if (picasso_job_done) pi_out <= 1'b0;
        end
    end

    // Completion counter (wraps naturally) and sticky spurious-done flag.
    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            done_cnt          <= 8'd0;
            err_spurious_done <= 1'b0;
        end else begin
            done_cnt <= done_cnt + 8'(eu_done_ok) + 8'(pi_done_ok);
            if ((euclid_job_done && !eu_out) || (picasso_job_done && !pi_out))
                err_spurious_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_syn_gpu_job_sched.sv
// Purpose: directed checks of syn_gpu_job_sched in relaxed (r) and strict (s) ordering modes side by side.
// Latency: both instances share every input; expected cycles are hand-derived from the issue rules.
// Backpressure: engine busy inputs and the queue-full case are driven explicitly.
module tb_syn_gpu_job_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid, job_type;
    logic [63:0] job_data;
    logic        eb, ed, pb, pd;

    logic        job_ready, eu_start, pi_start, sched_idle, err;
    logic [63:0] eu_data;
    logic [47:0] pi_data;
    logic [2:0]  pending_cnt;
    logic [7:0]  done_cnt;

    logic        s_job_ready, s_eu_start, s_pi_start, s_sched_idle, s_err;
    logic [63:0] s_eu_data;
    logic [47:0] s_pi_data;
    logic [2:0]  s_pending_cnt;
    logic [7:0]  s_done_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    syn_gpu_job_sched #(.DRAW_W(64), .FILL_W(48), .JOB_W(64), .STRICT_ORDER(0)) u_relaxed (
        .clk_ir(clk), .rst_il(rst),
        .job_valid(job_valid), .job_type(job_type), .job_data(job_data), .job_ready(job_ready),
        .euclid_job_start(eu_start), .euclid_job_data(eu_data),
        .euclid_busy(eb), .euclid_job_done(ed),
        .picasso_job_start(pi_start), .picasso_job_data(pi_data),
        .picasso_busy(pb), .picasso_job_done(pd),
        .pending_cnt(pending_cnt), .done_cnt(done_cnt),
        .sched_idle(sched_idle), .err_spurious_done(err)
    );

    syn_gpu_job_sched #(.DRAW_W(64), .FILL_W(48), .JOB_W(64), .STRICT_ORDER(1)) u_strict (
        .clk_ir(clk), .rst_il(rst),
        .job_valid(job_valid), .job_type(job_type), .job_data(job_data), .job_ready(s_job_ready),
        .euclid_job_start(s_eu_start), .euclid_job_data(s_eu_data),
        .euclid_busy(eb), .euclid_job_done(ed),
        .picasso_job_start(s_pi_start), .picasso_job_data(s_pi_data),
        .picasso_busy(pb), .picasso_job_done(pd),
        .pending_cnt(s_pending_cnt), .done_cnt(s_done_cnt),
        .sched_idle(s_sched_idle), .err_spurious_done(s_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; job_valid = 1'b0; job_type = 1'b0; job_data = '0;
        eb = 1'b0; ed = 1'b0; pb = 1'b0; pd = 1'b0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] st, s_st;
        rst = 1'b1; eb = 1'b0; ed = 1'b0; pb = 1'b0; pd = 1'b0;
        job_valid = 1'b1; job_type = 1'b0; job_data = 64'hDEAD;
        tick; tick;
        // {ready, idle, pending, done_cnt, err, eu_start, pi_start}
        st   = {job_ready, sched_idle, pending_cnt, done_cnt, err, eu_start, pi_start};
        s_st = {s_job_ready, s_sched_idle, s_pending_cnt, s_done_cnt, s_err, s_eu_start, s_pi_start};
        tests++;
        if (st !== 16'hC000) begin
            fails++; $display("FAIL reset_status_relaxed: got %h expected c000", st);
        end
        tests++;
        if (s_st !== 16'hC000) begin
            fails++; $display("FAIL reset_status_strict: got %h expected c000", s_st);
        end
        tests++;
        if ({eu_data, pi_data, s_eu_data, s_pi_data} !== '0) begin
            fails++; $display("FAIL reset_data: got %h %h %h %h expected all 0", eu_data, pi_data, s_eu_data, s_pi_data);
        end
        rst = 1'b0; job_valid = 1'b0;
        tick;
        tests++;
        if (pending_cnt !== 3'd0 || eu_start !== 1'b0) begin
            fails++; $display("FAIL reset_push_ignored: pending %0d start %b expected 0 0", pending_cnt, eu_start);
        end
    endtask

    task automatic test_basic_latency;
        do_reset;
        job_valid = 1'b1; job_type = 1'b0; job_data = 64'hA5;   // cycle 0
        tick;                                                   // cycle 1
        job_valid = 1'b0;
        tests++;
        if (pending_cnt !== 3'd1 || eu_start !== 1'b0) begin
            fails++; $display("FAIL basic_c1: pending %0d start %b expected 1 0", pending_cnt, eu_start);
        end
        tick;                                                   // cycle 2
        tests++;
        if (eu_start !== 1'b1 || pi_start !== 1'b0 || eu_data !== 64'hA5 || pending_cnt !== 3'd1) begin
            fails++; $display("FAIL basic_c2: eu_start %b pi_start %b data %h pending %0d expected 1 0 a5 1", eu_start, pi_start, eu_data, pending_cnt);
        end
        tick;                                                   // cycle 3
        tests++;
        if (eu_start !== 1'b0 || pending_cnt !== 3'd0 || sched_idle !== 1'b0) begin
            fails++; $display("FAIL basic_c3: start %b pending %0d idle %b expected 0 0 0", eu_start, pending_cnt, sched_idle);
        end
        ed = 1'b1;
        tick;
        ed = 1'b0;
        tests++;
        if (done_cnt !== 8'd1 || err !== 1'b0 || sched_idle !== 1'b1 || eu_data !== 64'hA5) begin
            fails++; $display("FAIL basic_done: done_cnt %0d err %b idle %b data %h expected 1 0 1 a5", done_cnt, err, sched_idle, eu_data);
        end
    endtask

    task automatic test_backpressure_and_reset;
        logic seen;
        do_reset;
        eb = 1'b1; pb = 1'b1; seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            job_valid = 1'b1; job_type = k[0]; job_data = 64'(k + 1);
            tests++;
            if (job_ready !== (k < 4)) begin
                fails++; $display("FAIL bp_ready_k%0d: got %b expected %b", k, job_ready, (k < 4));
            end
            seen = seen | eu_start | pi_start | s_eu_start | s_pi_start;
            tick;
        end
        tests++;
        if (pending_cnt !== 3'd4 || job_ready !== 1'b0) begin
            fails++; $display("FAIL bp_full: pending %0d ready %b expected 4 0", pending_cnt, job_ready);
        end
        job_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen = seen | eu_start | pi_start | s_eu_start | s_pi_start;
            tick;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++; $display("FAIL bp_no_start: got start %b expected 0", seen);
        end
        eb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (eu_start) break;
        end
        tests++;
        if (eu_start !== 1'b1 || eu_data !== 64'd1 || s_eu_start !== 1'b1) begin
            fails++; $display("FAIL bp_release: start %b data %h strict_start %b expected 1 1 1", eu_start, eu_data, s_eu_start);
        end
        tick;
        tests++;
        if (pending_cnt !== 3'd3) begin
            fails++; $display("FAIL bp_after_pop: pending %0d expected 3", pending_cnt);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0; pb = 1'b0;
        tests++;
        if (pending_cnt !== 3'd0 || job_ready !== 1'b1 || eu_data !== 64'd0) begin
            fails++; $display("FAIL rst_mid_job: pending %0d ready %b data %h expected 0 1 0", pending_cnt, job_ready, eu_data);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen = seen | eu_start | pi_start;
            tick;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++; $display("FAIL rst_no_start: got start %b expected 0", seen);
        end
        ed = 1'b1;
        tick;
        ed = 1'b0;
        tests++;
        if (err !== 1'b1 || done_cnt !== 8'd0) begin
            fails++; $display("FAIL rst_late_done: err %b done_cnt %0d expected 1 0", err, done_cnt);
        end
    endtask

    task automatic test_fill_after_draw;
        int e1, p1, sp1;
        e1 = -1; p1 = -1; sp1 = -1;
        do_reset;
        for (int c = 0; c < 26; c++) begin
            job_valid = (c == 0) || (c == 1);
            job_type  = (c == 1);
            job_data  = (c == 0) ? 64'h11 : 64'h22;
            ed = (c == 20);
            pd = (c == 24);
            if (eu_start && e1 < 0) e1 = c;
            if (pi_start && p1 < 0) p1 = c;
            if (s_pi_start && sp1 < 0) sp1 = c;
            tick;
        end
        job_valid = 1'b0; ed = 1'b0; pd = 1'b0;
        tests++;
        if (e1 != 2 || p1 != 22 || sp1 != 22) begin
            fails++; $display("FAIL raw_hazard: eu %0d pi %0d strict_pi %0d expected 2 22 22", e1, p1, sp1);
        end
        tests++;
        if (pi_data !== 48'h22 || eu_data !== 64'h11 || done_cnt !== 8'd2 || sched_idle !== 1'b1) begin
            fails++; $display("FAIL raw_end: pi %h eu %h done %0d idle %b expected 22 11 2 1", pi_data, eu_data, done_cnt, sched_idle);
        end
    endtask

    task automatic test_draw_after_fill;
        int e1, p1, se1;
        e1 = -1; p1 = -1; se1 = -1;
        do_reset;
        for (int c = 0; c < 17; c++) begin
            job_valid = (c == 0) || (c == 1);
            job_type  = (c == 0);
            job_data  = (c == 0) ? 64'h33 : 64'h44;
            pd = (c == 10);
            ed = (c == 14);
            if (eu_start && e1 < 0) e1 = c;
            if (pi_start && p1 < 0) p1 = c;
            if (s_eu_start && se1 < 0) se1 = c;
            tick;
        end
        job_valid = 1'b0; ed = 1'b0; pd = 1'b0;
        tests++;
        if (p1 != 2 || e1 != 4 || se1 != 12) begin
            fails++; $display("FAIL overlap: pi %0d eu %0d strict_eu %0d expected 2 4 12", p1, e1, se1);
        end
        tests++;
        if (eu_data !== 64'h44 || done_cnt !== 8'd2 || s_done_cnt !== 8'd2 || err !== 1'b0 || s_err !== 1'b0) begin
            fails++; $display("FAIL overlap_end: data %h done %0d/%0d err %b/%b expected 44 2/2 0/0", eu_data, done_cnt, s_done_cnt, err, s_err);
        end
    endtask

    task automatic test_spurious_done;
        do_reset;
        pd = 1'b1;
        tick;
        pd = 1'b0;
        tests++;
        if (err !== 1'b1 || done_cnt !== 8'd0 || s_err !== 1'b1) begin
            fails++; $display("FAIL spurious_idle: err %b done %0d strict_err %b expected 1 0 1", err, done_cnt, s_err);
        end
        // done in the same cycle as the start: the start wins
        do_reset;
        for (int c = 0; c < 5; c++) begin
            job_valid = (c == 0); job_type = 1'b0; job_data = 64'h5A;
            ed = (c == 2);
            tick;
        end
        job_valid = 1'b0; ed = 1'b0;
        tests++;
        if (err !== 1'b1 || done_cnt !== 8'd0 || sched_idle !== 1'b0) begin
            fails++; $display("FAIL start_done_same: err %b done %0d idle %b expected 1 0 0", err, done_cnt, sched_idle);
        end
        ed = 1'b1;
        tick;
        ed = 1'b0;
        tests++;
        if (done_cnt !== 8'd1 || sched_idle !== 1'b1) begin
            fails++; $display("FAIL start_done_later: done %0d idle %b expected 1 1", done_cnt, sched_idle);
        end
    endtask

    task automatic test_dual_done;
        do_reset;
        for (int c = 0; c < 7; c++) begin
            job_valid = (c == 0) || (c == 1);
            job_type  = (c == 0);
            job_data  = 64'h77;
            ed = (c == 6);
            pd = (c == 6);
            tick;
        end
        job_valid = 1'b0; ed = 1'b0; pd = 1'b0;
        tests++;
        if (done_cnt !== 8'd2 || err !== 1'b0) begin
            fails++; $display("FAIL dual_done_relaxed: done %0d err %b expected 2 0", done_cnt, err);
        end
        tests++;
        if (s_done_cnt !== 8'd1 || s_err !== 1'b1) begin
            fails++; $display("FAIL dual_done_strict: done %0d err %b expected 1 1", s_done_cnt, s_err);
        end
    endtask

    task automatic test_back_to_back_wrap;
        int timeouts;
        timeouts = 0;
        do_reset;
        for (int n = 1; n <= 256; n++) begin
            job_valid = 1'b1; job_type = 1'b0; job_data = 64'(n);
            tick;
            job_valid = 1'b0;
            for (int i = 0; i < 6; i++) begin
                if (eu_start) break;
                tick;
            end
            if (!eu_start) timeouts++;
            tick;
            ed = 1'b1;
            tick;
            ed = 1'b0;
            if (n == 255) begin
                tests++;
                if (done_cnt !== 8'd255) begin
                    fails++; $display("FAIL wrap_255: done %0d expected 255", done_cnt);
                end
            end
        end
        tests++;
        if (timeouts != 0) begin
            fails++; $display("FAIL wrap_start_timeout: got %0d timeouts expected 0", timeouts);
        end
        tests++;
        if (done_cnt !== 8'd0 || s_done_cnt !== 8'd0 || err !== 1'b0 || eu_data !== 64'd256) begin
            fails++; $display("FAIL wrap_256: done %0d/%0d err %b data %h expected 0/0 0 100", done_cnt, s_done_cnt, err, eu_data);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic_latency;
        test_backpressure_and_reset;
        test_fill_after_draw;
        test_draw_after_fill;
        test_spurious_done;
        test_dual_done;
        test_back_to_back_wrap;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
